// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic [4:0] A3_E;
    logic [4:0] A3_M;
    logic [1:0] Res_E;
    logic [1:0] Res_M;
    logic       md_use_D;
    logic       md_start_E;
    logic       md_div_E;
    logic       exc_M;
    logic       eret_M;
    logic       stall_PC;
    logic       stall_IFID;
    logic       IFID_clr;
    logic       IDEX_clr;
    logic       EXMEM_clr;
    logic       MEMWB_clr;
    logic       md_busy;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, A3_E, A3_M, Res_E, Res_M,
               md_use_D, md_start_E, md_div_E, exc_M, eret_M,
        input  stall_PC, stall_IFID, IFID_clr, IDEX_clr, EXMEM_clr, MEMWB_clr, md_busy
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, A3_E, A3_M, Res_E, Res_M,
               md_use_D, md_start_E, md_div_E, exc_M, eret_M,
        output stall_PC, stall_IFID, IFID_clr, IDEX_clr, EXMEM_clr, MEMWB_clr, md_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW / mult-div stalls, exception and eret flush strobes.
// Defining HAZ_STALL_CNT_EN adds the stall_cnt statistics output.
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    localparam logic [1:0] RES_ALU   = 2'b00;
    localparam logic [1:0] RES_DM    = 2'b01;
    localparam logic [1:0] RES_NW    = 2'b11;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef enum logic {IDLE, BUSY} mdState_t;

    mdState_t         state;
    logic [CNT_W-1:0] cnt;

    logic [1:0] tnewE;
    logic [1:0] tnewM;
    logic       stallRs;
    logic       stallRt;
    logic       stallMd;
    logic       stall;
    logic       flush;

    // Cycles until the in-flight result is available; PC and NW classes are ready now.
    always_comb begin
        tnewE = 2'd0;
        tnewM = 2'd0;
        case (hz.Res_E)
            RES_ALU: tnewE = 2'd1;
            RES_DM:  tnewE = 2'd2;
            default: tnewE = 2'd0;
        endcase
        if (hz.Res_M == RES_DM) tnewM = 2'd1;
    end

    function automatic logic rawStall(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] a3E,
        input logic [1:0] resE,
        input logic [1:0] tnE,
        input logic [4:0] a3M,
        input logic [1:0] resM,
        input logic [1:0] tnM
    );
        logic hitE;
        logic hitM;
        hitE = (src == a3E) && (resE != RES_NW) && (tuse < tnE);
        hitM = (src == a3M) && (resM != RES_NW) && (tuse < tnM);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (hitE || hitM);
    endfunction

    assign stallRs = rawStall(hz.rs_D, hz.tuse_rs_D, hz.A3_E, hz.Res_E, tnewE,
                              hz.A3_M, hz.Res_M, tnewM);
    assign stallRt = rawStall(hz.rt_D, hz.tuse_rt_D, hz.A3_E, hz.Res_E, tnewE,
                              hz.A3_M, hz.Res_M, tnewM);
    assign stallMd = hz.md_use_D && ((state == BUSY) || hz.md_start_E);
    assign stall   = stallRs || stallRt || stallMd;
    assign flush   = hz.exc_M || hz.eret_M;

    // Flush wins over stall so the PC can be redirected; everything is quiet in reset.
    always_comb begin
        hz.stall_PC   = 1'b0;
        hz.stall_IFID = 1'b0;
        hz.IFID_clr   = 1'b0;
        hz.IDEX_clr   = 1'b0;
        hz.EXMEM_clr  = 1'b0;
        hz.MEMWB_clr  = 1'b0;
        if (reset) begin
            if (flush) begin
                hz.IFID_clr  = 1'b1;
                hz.IDEX_clr  = 1'b1;
                hz.EXMEM_clr = 1'b1;
                hz.MEMWB_clr = hz.exc_M;
            end else if (stall) begin
                hz.stall_PC   = 1'b1;
                hz.stall_IFID = 1'b1;
                hz.IDEX_clr   = 1'b1;
            end
        end
    end

    assign hz.md_busy = (state == BUSY);

    // Mult/div busy window; a running operation completes even across an exception.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz.md_start_E && !hz.exc_M) begin
                        state <= BUSY;
                        cnt   <= hz.md_div_E ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAZ_STALL_CNT_EN
    // Counts only stalls that actually hold the pipe; flushed cycles are not stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 stall_cnt <= '0;
        else if (stall && !flush)   stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; checks stall_cnt when HAZ_STALL_CNT_EN is defined.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;

    pipe_hazard_ctrl_if hz();

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    pipe_hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .hz        (hz)
`ifdef HAZ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {stall_PC, stall_IFID, IFID_clr, IDEX_clr, EXMEM_clr, MEMWB_clr, md_busy}
    localparam logic [6:0] E_NONE  = 7'b0000000;
    localparam logic [6:0] E_STALL = 7'b1101000;
    localparam logic [6:0] E_EXC   = 7'b0011110;
    localparam logic [6:0] E_ERET  = 7'b0011100;
    localparam logic [6:0] E_BUSY  = 7'b0000001;

    logic [6:0] obsVec;
    assign obsVec = {hz.stall_PC, hz.stall_IFID, hz.IFID_clr, hz.IDEX_clr,
                     hz.EXMEM_clr, hz.MEMWB_clr, hz.md_busy};

    int nVec = 0;
    int nErr = 0;
    logic [6:0] expQ[$];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven; expected value is queued, then compared mid-cycle.
    task automatic step(input string tag, input logic [6:0] exp);
        logic [6:0] e;
        expQ.push_back(exp);
        @(negedge clk);
        e = expQ.pop_front();
        checkVal(tag, 32'(obsVec), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        hz.rs_D       = 5'd0;
        hz.rt_D       = 5'd0;
        hz.tuse_rs_D  = 2'd3;
        hz.tuse_rt_D  = 2'd3;
        hz.A3_E       = 5'd0;
        hz.A3_M       = 5'd0;
        hz.Res_E      = 2'b11;
        hz.Res_M      = 2'b11;
        hz.md_use_D   = 1'b0;
        hz.md_start_E = 1'b0;
        hz.md_div_E   = 1'b0;
        hz.exc_M      = 1'b0;
        hz.eret_M     = 1'b0;
    endtask

    task automatic loadUse();
        hz.rs_D      = 5'd1;
        hz.tuse_rs_D = 2'd1;
        hz.A3_E      = 5'd1;
        hz.Res_E     = 2'b01;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        clearIn();
        @(posedge clk);
        #1;

        // Hazards and a start presented while in reset produce nothing
        loadUse();
        hz.md_use_D   = 1'b1;
        hz.md_start_E = 1'b1;
        step("inReset", E_NONE);
        reset = 1'b1;
        clearIn();
        step("idle", E_NONE);

`ifdef HAZ_STALL_CNT_EN
        loadUse();
        for (int i = 0; i < 3; i++) step("cntStall", E_STALL);
        hz.exc_M = 1'b1;
        step("cntFlush", E_EXC);
        clearIn();
        step("cntIdle", E_NONE);
        checkVal("stallCnt", stall_cnt, 32'd3);
`endif

        // Load-use: DM producer in EX stalls, once in MEM it no longer does
        loadUse();
        step("ldUseE", E_STALL);
        hz.A3_E  = 5'd0;
        hz.Res_E = 2'b11;
        hz.A3_M  = 5'd1;
        hz.Res_M = 2'b01;
        step("ldUseM", E_NONE);
        hz.tuse_rs_D = 2'd0;
        step("dmMemTuse0", E_STALL);
        clearIn();

        // Branch on rt with ALU producer in EX, then boundary variants
        hz.rt_D = 5'd5; hz.tuse_rt_D = 2'd0; hz.A3_E = 5'd5; hz.Res_E = 2'b00;
        step("beqRt", E_STALL);
        hz.tuse_rt_D = 2'd3;
        step("rtUnused", E_NONE);
        clearIn();
        hz.rs_D = 5'd0; hz.tuse_rs_D = 2'd0; hz.A3_E = 5'd0; hz.Res_E = 2'b00;
        step("zeroRs", E_NONE);
        hz.rs_D = 5'd5; hz.tuse_rs_D = 2'd1; hz.A3_E = 5'd5;
        step("aluTuse1", E_NONE);
        hz.tuse_rs_D = 2'd0; hz.Res_E = 2'b10;
        step("pcClass", E_NONE);
        hz.Res_E = 2'b11;
        step("nwClass", E_NONE);
        clearIn();
        hz.rt_D = 5'd7; hz.tuse_rt_D = 2'd1; hz.A3_E = 5'd7; hz.Res_E = 2'b01;
        step("dmExRt", E_STALL);
        clearIn();

        // Divide with mflo waiting in ID: ten busy cycles, stall through the last one
        hz.md_start_E = 1'b1; hz.md_div_E = 1'b1; hz.md_use_D = 1'b1;
        step("divStart", E_STALL);
        hz.md_start_E = 1'b0; hz.md_div_E = 1'b0;
        for (int i = 0; i < 10; i++) step("divBusy", E_STALL | E_BUSY);
        step("divDone", E_NONE);
        clearIn();

        // Flush priority over stall; eret keeps MEM/WB
        hz.rs_D = 5'd1; hz.tuse_rs_D = 2'd0; hz.A3_E = 5'd1; hz.Res_E = 2'b00;
        hz.exc_M = 1'b1;
        step("excFlush", E_EXC);
        hz.exc_M = 1'b0; hz.eret_M = 1'b1;
        step("eretFlush", E_ERET);
        hz.exc_M = 1'b1;
        step("excEret", E_EXC);
        clearIn();

        // Start cancelled by a same-cycle exception
        hz.md_start_E = 1'b1; hz.exc_M = 1'b1;
        step("startCancel", E_EXC);
        clearIn();
        step("cancelIdle", E_NONE);

        // Multiply runs five cycles and survives an exception
        hz.md_start_E = 1'b1;
        step("multStart", E_NONE);
        clearIn();
        step("multBusy", E_BUSY);
        hz.exc_M = 1'b1;
        step("excDuringBusy", E_EXC | E_BUSY);
        clearIn();
        for (int i = 0; i < 3; i++) step("multBusy", E_BUSY);
        step("multDone", E_NONE);

        // Reset pulled low at counter value 6 aborts the window without a clock edge
        hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
        step("div2Start", E_NONE);
        clearIn();
        for (int i = 0; i < 3; i++) step("div2Busy", E_BUSY);
        hz.md_use_D = 1'b1;
        #1;
        checkVal("preRst", 32'(obsVec), 32'(E_STALL | E_BUSY));
        reset = 1'b0;
        #1;
        checkVal("rstAbortBusy", 32'(hz.md_busy), 32'd0);
        checkVal("rstAbortOut", 32'(obsVec), 32'(E_NONE));
        step("holdReset", E_NONE);
        reset = 1'b1;
        clearIn();
        step("postReset", E_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Generates the stall and clear strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. MEMWB_clr drives the MEM/WB register directly.
- Derives RAW stalls from Tuse/Tnew, using the 2-bit result-class codes carried down the pipe (Res_E/Res_M/Res_W).
- Sequences the multi-cycle mult/div busy window and the exception/eret flush.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, busy counter width; must hold DIV_CYCLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs_D, rt_D  in  5 each  source register numbers in ID.
- tuse_rs_D, tuse_rt_D  in  2 each  cycles until the operand is needed; 3 = operand unused.
- A3_E, A3_M  in  5 each  destination register in EX / MEM.
- Res_E, Res_M  in  2 each  result class: 00 ALU, 01 DM, 10 PC, 11 NW (no write).
- md_use_D  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- md_start_E  in  1  EX instruction starts the mult/div unit.
- md_div_E  in  1  1 = the started operation is a divide.
- exc_M  in  1  exception or interrupt taken on the MEM-stage instruction.
- eret_M  in  1  eret in MEM.
- stall_PC, stall_IFID  out  1 each  hold PC / IF-ID.
- IFID_clr, IDEX_clr, EXMEM_clr, MEMWB_clr  out  1 each  synchronous bubble insertion into the named register.
- md_busy  out  1  mult/div unit busy.

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE, busy counter to 0, md_busy=0. All stall/clear outputs are 0 while in reset.
- Tnew at EX: ALU=1, DM=2, PC=0, NW=0.
- Tnew at MEM: DM=1, all other classes 0.
- WB never stalls; it is forwarded.
- stall_rs = (rs_D!=0) & (tuse_rs_D!=3) & [((rs_D==A3_E) & (Res_E!=NW) & (tuse_rs_D<TnewE)) | ((rs_D==A3_M) & (Res_M!=NW) & (tuse_rs_D<TnewM))].
- stall_rt is the same expression using the rt inputs.
- stall_md = md_use_D & (md_busy | md_start_E).
- stall = stall_rs | stall_rt | stall_md.
- Stall response: stall_PC=1, stall_IFID=1, IDEX_clr=1 (bubble into EX).
- All stall/clear outputs are combinational from inputs and current state.
- Busy FSM states: IDLE and BUSY.
  - IDLE → BUSY on md_start_E & ~exc_M. Counter loads MULT_CYCLES-1 (mult) or DIV_CYCLES-1 (div, when md_div_E=1).
  - BUSY: counter decrements each cycle; BUSY → IDLE when the counter is 0.
  - md_busy = (state==BUSY).
  - md_start_E while already BUSY: ignored; the stall rules make this unreachable.
- Flush: exc_M or eret_M asserts IFID_clr, IDEX_clr and EXMEM_clr in that cycle. stall_PC and stall_IFID are forced to 0 so the PC can be redirected.
  - exc_M additionally asserts MEMWB_clr: the faulting instruction does not commit.
  - eret_M leaves MEMWB_clr=0.
- Flush has priority over stall when both apply in the same cycle.
- md_start_E together with exc_M: the start is cancelled and the FSM stays IDLE.
- An operation already BUSY when an exception occurs runs to completion (HI/LO semantics).
- Reset asserted mid-operation: the busy window aborts immediately.
- No clear/stall pulse extends past the triggering cycle; there is no hidden latency.

Optional Feature:
- Macro HAZ_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0], cleared by reset.
  - Increments by 1 on each cycle where stall=1 and no flush is active.
  - Wraps at 2^32-1 to 0.
- Undefined: no port, no counter; behaviour is otherwise identical.

Test Plan:
- lw $1 in EX (Res_E=01, A3_E=1), ID addu using rs=1 with tuse_rs=1 → stall_PC=stall_IFID=IDEX_clr=1 for 1 cycle. Next cycle (lw in MEM, TnewM=1) → no stall.
- ID beq (tuse=0) on rt=5 with ALU producer in EX (A3_E=5) → stall. Same case with rs=0 → no stall.
- md_start_E with md_div_E=1, then mflo in ID → md_busy=1 for exactly 10 cycles, stall held through the last busy cycle, released the cycle md_busy falls.
- exc_M=1 with stall conditions true → IFID/IDEX/EXMEM/MEMWB_clr=1, stall_PC=0. Same cycle eret_M alone → MEMWB_clr=0.
- md_start_E and exc_M together → md_busy stays 0. Pull reset low during BUSY (count 6) → md_busy=0 immediately, without waiting for a clock edge.
- HAZ_STALL_CNT_EN defined: 3 RAW stall cycles plus 1 stall cycle overlapping a flush → stall_cnt=3.
